// File: rtl/mips_alu_pkg.sv
// -----------------------------------------------------------------------------
// mips_alu_pkg
// Shared definitions for the multi-cycle MIPS ALU:
//   - 4-bit opcode encodings OP_AND .. OP_DIV
//   - controller FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE)
//   - is_muldiv(op): true for the iterative multiply/divide opcodes
// -----------------------------------------------------------------------------
package mips_alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_MFHI  = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_MULT  = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_DIV   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // The four multiply/divide opcodes occupy 11xx.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op[3:2] == 2'b11);
    endfunction

endpackage

// File: rtl/mips_alu_muldiv.sv
// -----------------------------------------------------------------------------
// mips_alu_muldiv
// Iterative shift-add multiplier / restoring divider. Signed operations run on
// operand magnitudes; signs are fixed up on the final iteration.
// Ports:
//   clk, rst          clock, async active-high reset
//   start             load operands and begin (one-cycle pulse)
//   op_div            1 = divide, 0 = multiply
//   op_signed         1 = signed operands
//   a, b              multiplicand/multiplier or dividend/divisor
//   busy              iterations in progress
//   done              high during the last iteration; hi/lo are final then
//   hi, lo            final result: product {hi,lo} or remainder/quotient
// Exactly WIDTH iterations run after the load edge. hi/lo are driven
// combinationally from the last iteration so the owner can capture them on the
// same edge that completes the operation.
// -----------------------------------------------------------------------------
module mips_alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic             busy_r;
    logic             div_r;
    logic             neg_q_r;     // negate quotient / full product
    logic             neg_rem_r;   // negate remainder
    logic             div0_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] hi_r;        // partial product high half / remainder
    logic [WIDTH-1:0] lo_r;        // multiplier bits / dividend->quotient
    logic [WIDTH-1:0] d_r;         // multiplicand / divisor magnitude
    logic [WIDTH-1:0] a_r;         // raw dividend, returned in HI on div-by-zero

    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     shift_s;
    logic [WIDTH-1:0]   diff_s;
    logic               ge_s;
    logic [WIDTH-1:0]   nxt_hi_s;
    logic [WIDTH-1:0]   nxt_lo_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   fin_hi_s;
    logic [WIDTH-1:0]   fin_lo_s;

    assign mag_a_s = (op_signed && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    assign mag_b_s = (op_signed && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

    assign busy = busy_r;
    assign done = busy_r && (cnt_r == LAST_ITER);
    assign hi   = fin_hi_s;
    assign lo   = fin_lo_s;

    // One multiply or divide iteration from the current registers.
    always_comb begin
        sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, d_r} : {(WIDTH+1){1'b0}});
        shift_s = {hi_r, lo_r[WIDTH-1]};
        ge_s    = (shift_s >= {1'b0, d_r});
        // When ge_s holds the difference is below the divisor, so WIDTH bits suffice.
        diff_s  = shift_s[WIDTH-1:0] - d_r;
        if (div_r) begin
            nxt_hi_s = ge_s ? diff_s : shift_s[WIDTH-1:0];
            nxt_lo_s = {lo_r[WIDTH-2:0], ge_s};
        end else begin
            nxt_hi_s = sum_s[WIDTH:1];
            nxt_lo_s = {sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    // Sign fix-up and divide-by-zero substitution applied to the iteration result.
    always_comb begin
        prod_s     = {nxt_hi_s, nxt_lo_s};
        prod_fix_s = neg_q_r ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
        if (div_r) begin
            if (div0_r) begin
                fin_hi_s = a_r;
                fin_lo_s = {WIDTH{1'b1}};
            end else begin
                fin_hi_s = neg_rem_r ? ({WIDTH{1'b0}} - nxt_hi_s) : nxt_hi_s;
                fin_lo_s = neg_q_r   ? ({WIDTH{1'b0}} - nxt_lo_s) : nxt_lo_s;
            end
        end else begin
            fin_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            fin_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Operand load on start, then one iteration per cycle until done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r    <= 1'b0;
            div_r     <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            div0_r    <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            d_r       <= {WIDTH{1'b0}};
            a_r       <= {WIDTH{1'b0}};
        end else if (start) begin
            busy_r    <= 1'b1;
            div_r     <= op_div;
            neg_q_r   <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_r <= op_signed && a[WIDTH-1];
            div0_r    <= (b == {WIDTH{1'b0}});
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= op_div ? mag_a_s : mag_b_s;
            d_r       <= op_div ? mag_b_s : mag_a_s;
            a_r       <= a;
        end else if (busy_r) begin
            hi_r  <= nxt_hi_s;
            lo_r  <= nxt_lo_s;
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (done) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= 1'b1;
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: rtl/mips_alu_mc.sv
// -----------------------------------------------------------------------------
// mips_alu_mc
// Registered multi-cycle MIPS ALU with valid/ready handshake on both sides.
// Single-cycle ops complete one cycle after accept; MULT/MULTU/DIV/DIVU run
// WIDTH iterations in mips_alu_muldiv and write HI/LO, readable via MFHI/MFLO.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   request handshake (in_ready only in IDLE)
//   control_in[3:0]     opcode (see mips_alu_pkg)
//   in1, in2            operands; shift amount is in2[SHAMT_W-1:0]
//   out_valid/out_ready result handshake; result held until out_ready
//   alu_result          registered result
//   is_zero             registered (alu_result == 0)
//   overflow            signed ADD/SUB overflow
// Build option: define MIPS_ALU_OVERFLOW_EN to build overflow detection;
// otherwise overflow is tied to 0.
// -----------------------------------------------------------------------------
module mips_alu_mc
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       control_in,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             is_zero,
    output logic             overflow
);

    localparam int SHAMT_W = $clog2(WIDTH);

    state_t           state_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;

    logic               accept_s;
    logic               start_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic [WIDTH-1:0]   alu_s;
    logic               md_busy_s;
    logic               md_done_s;
    logic [WIDTH-1:0]   md_hi_s;
    logic [WIDTH-1:0]   md_lo_s;

    assign in_ready   = (state_r == ST_IDLE);
    assign out_valid  = (state_r == ST_DONE);
    assign accept_s   = in_valid && in_ready;
    assign start_s    = accept_s && is_muldiv(control_in);
    assign shamt_s    = in2[SHAMT_W-1:0];
    assign alu_result = result_r;
    assign is_zero    = zero_r;

    mips_alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .op_div    (control_in[1]),
        .op_signed (control_in[0]),
        .a         (in1),
        .b         (in2),
        .busy      (md_busy_s),
        .done      (md_done_s),
        .hi        (md_hi_s),
        .lo        (md_lo_s)
    );

    // Single-cycle datapath result for the current opcode.
    always_comb begin
        alu_s = {WIDTH{1'b0}};
        case (control_in)
            OP_AND:  alu_s = in1 & in2;
            OP_OR:   alu_s = in1 | in2;
            OP_ADD:  alu_s = in1 + in2;
            OP_XOR:  alu_s = in1 ^ in2;
            OP_MFHI: alu_s = hi_r;
            OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SUB:  alu_s = in1 - in2;
            OP_SLTU: alu_s = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            OP_SLL:  alu_s = in1 << shamt_s;
            OP_SRL:  alu_s = in1 >> shamt_s;
            OP_SRA:  alu_s = $signed(in1) >>> shamt_s;
            OP_MFLO: alu_s = lo_r;
            default: alu_s = {WIDTH{1'b0}};   // mul/div results come from u_muldiv
        endcase
    end

    // Controller FSM with HI/LO and the registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r <= ST_BUSY;
                    end else if (accept_s) begin
                        state_r  <= ST_DONE;
                        result_r <= alu_s;
                        zero_r   <= (alu_s == {WIDTH{1'b0}});
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (md_done_s) begin
                        state_r  <= ST_DONE;
                        hi_r     <= md_hi_s;
                        lo_r     <= md_lo_s;
                        result_r <= md_lo_s;
                        zero_r   <= (md_lo_s == {WIDTH{1'b0}});
                    end else if (!md_busy_s) begin
                        // Engine idle while we wait on it: recover instead of hanging.
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

`ifdef MIPS_ALU_OVERFLOW_EN
    logic ovf_s;
    logic ovf_r;

    // Signed overflow of ADD/SUB, judged on the wrapped result's sign.
    always_comb begin
        ovf_s = 1'b0;
        case (control_in)
            OP_ADD:  ovf_s = (in1[WIDTH-1] == in2[WIDTH-1]) && (alu_s[WIDTH-1] != in1[WIDTH-1]);
            OP_SUB:  ovf_s = (in1[WIDTH-1] != in2[WIDTH-1]) && (alu_s[WIDTH-1] != in1[WIDTH-1]);
            default: ovf_s = 1'b0;
        endcase
    end

    // Overflow flag registered alongside the result at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (accept_s) begin
            ovf_r <= ovf_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign overflow = ovf_r;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mips_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_mips_alu_mc
// Self-checking bench for mips_alu_mc (WIDTH = 32): directed cases followed by
// randomized operations compared against a 64-bit arithmetic reference model
// that tracks HI/LO. Overflow expectations follow MIPS_ALU_OVERFLOW_EN.
// -----------------------------------------------------------------------------
module tb_mips_alu_mc;
    import mips_alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  control_in;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        is_zero;
    logic        overflow;

    int          chk_cnt;
    int          err_cnt;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mips_alu_mc #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .control_in (control_in),
        .in1        (in1),
        .in2        (in2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .is_zero    (is_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic; updates m_hi/m_lo for mul/div.
    task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ovf, output int lat);
        logic signed [63:0] sa, sb, s, sq, sr;
        logic [63:0] p;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ovf = 1'b0;
        lat = 1;
        res = 32'h0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_ADD: begin
                s = sa + sb; res = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                s = sa - sb; res = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_MFHI: res = m_hi;
            OP_MFLO: res = m_lo;
            OP_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: res = ({32'h0, a} < {32'h0, b}) ? 32'd1 : 32'd0;
            OP_SLL:  res = a << b[4:0];
            OP_SRL:  res = a >> b[4:0];
            OP_SRA: begin s = sa >>> b[4:0]; res = s[31:0]; end
            OP_MULTU, OP_MULT: begin
                if (op == OP_MULT) p = sa * sb;
                else               p = {32'h0, a} * {32'h0, b};
                m_hi = p[63:32]; m_lo = p[31:0];
                res = m_lo; lat = 33;
            end
            default: begin // DIVU, DIV
                if (b == 32'h0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else if (op == OP_DIV) begin
                    sq = sa / sb; sr = sa % sb;
                    m_lo = sq[31:0]; m_hi = sr[31:0];
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
                res = m_lo; lat = 33;
            end
        endcase
    endtask

    // Issue one op, check latency/result/flags, hold for 'stall' cycles, then drain.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int stall);
        logic [31:0] e_res;
        logic        e_ovf;
        int          e_lat;
        int          n;
        ref_op(op, a, b, e_res, e_ovf, e_lat);
`ifndef MIPS_ALU_OVERFLOW_EN
        e_ovf = 1'b0;
`endif
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("in_ready before issue", in_ready, 1'b1);
        in_valid = 1'b1; control_in = op; in1 = a; in2 = b;
        @(posedge clk); #1;
        n = 1;
        while (!out_valid && n < 100) begin
            // Requests while busy must be ignored.
            in_valid = 1'(($urandom_range(0, 1)));
            control_in = 4'($urandom_range(0, 15)); in1 = $urandom; in2 = $urandom;
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0; in1 = $urandom; in2 = $urandom;
        check($sformatf("latency op%0d", op), 64'(n), 64'(e_lat));
        check($sformatf("result op%0d a=%h b=%h", op, a, b), alu_result, e_res);
        check($sformatf("is_zero op%0d", op), is_zero, (e_res == 32'h0));
        check($sformatf("overflow op%0d", op), overflow, e_ovf);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("held result", alu_result, e_res);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid drop", out_valid, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] e_res;
        logic        e_ovf;
        int          e_lat;
        chk_cnt = 0; err_cnt = 0;
        m_hi = 32'h0; m_lo = 32'h0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        control_in = 4'h0; in1 = 32'h0; in2 = 32'h0;
        @(posedge clk); #1;
        check("reset out_valid", out_valid, 1'b0);
        check("reset result", alu_result, 32'h0);
        check("reset is_zero", is_zero, 1'b1);
        check("reset overflow", overflow, 1'b0);
        rst = 1'b0;
        #1;
        check("in_ready after reset", in_ready, 1'b1);

        // Directed cases.
        run_op(OP_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op(OP_SUB,   32'h0000_0005, 32'h0000_0005, 0);
        run_op(OP_SUB,   32'h8000_0000, 32'h0000_0001, 1);
        run_op(OP_SLT,   32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(OP_SLTU,  32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(OP_SRA,   32'h8000_0000, 32'h0000_0024, 0);
        run_op(OP_MFHI,  32'h0, 32'h0, 0);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 2);
        run_op(OP_MFHI,  32'h0, 32'h0, 0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(OP_MFHI,  32'h0, 32'h0, 0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0);
        run_op(OP_MFHI,  32'h0, 32'h0, 0);
        run_op(OP_DIVU,  32'h0000_0009, 32'h0000_0000, 0);
        run_op(OP_MFHI,  32'h0, 32'h0, 0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(OP_MFHI,  32'h0, 32'h0, 0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 0);
        run_op(OP_MFHI,  32'h0, 32'h0, 0);
        run_op(OP_MULT,  32'h1234_5678, 32'h9ABC_DEF0, 0);

        // Backpressure: AND result held for 10 cycles while requests are ignored.
        ref_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, e_res, e_ovf, e_lat);
        in_valid = 1'b1; control_in = OP_AND; in1 = 32'hF0F0_1234; in2 = 32'h0FF0_FF00;
        @(posedge clk); #1;
        check("bp out_valid", out_valid, 1'b1);
        check("bp result", alu_result, e_res);
        for (int i = 0; i < 10; i++) begin
            control_in = 4'($urandom_range(0, 15)); in1 = $urandom; in2 = $urandom;
            @(posedge clk); #1;
            check("bp hold valid", out_valid, 1'b1);
            check("bp hold result", alu_result, e_res);
            check("bp in_ready low", in_ready, 1'b0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp idle in_ready", in_ready, 1'b1);
        check("bp idle out_valid", out_valid, 1'b0);
        run_op(OP_MFLO, 32'h0, 32'h0, 0);
        run_op(OP_MFHI, 32'h0, 32'h0, 0);

        // Reset during the fifth MULT iteration.
        in_valid = 1'b1; control_in = OP_MULT; in1 = 32'hFFFF_FFFD; in2 = 32'h0000_0007;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst is_zero", is_zero, 1'b1);
        check("midrst result", alu_result, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0;
        #1;
        check("midrst in_ready", in_ready, 1'b1);
        check("midrst out_valid after", out_valid, 1'b0);
        run_op(OP_MFHI, 32'h0, 32'h0, 0);
        run_op(OP_MFLO, 32'h0, 32'h0, 0);

        // Randomized operations.
        for (int k = 0; k < 250; k++) begin
            run_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
                   int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mips_alu_mc.md
Name: mips_alu_mc

Overview:
- Parametrised, registered, multi-cycle ALU for the single-cycle MIPS datapath; successor to the current combinational ALU.
- Widens the opcode set to logic, arithmetic, signed/unsigned compare and shifts.
- Adds iterative multiply/divide that writes internal HI/LO registers, plus MFHI/MFLO readback.
- Uses a valid/ready handshake on both sides so the control path can stall on long operations.

Parameters:
- WIDTH, 32, datapath width in bits; even, ≥8.
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from in2 (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- control_in  in  4  opcode.
- in1  in  WIDTH  operand A; shift source.
- in2  in  WIDTH  operand B; shift amount in [SHAMT_W-1:0].
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- alu_result  out  WIDTH  registered result.
- is_zero  out  1  registered (alu_result == 0).
- overflow  out  1  signed overflow flag (see Optional Feature).

Behaviour:
- Opcodes (existing encodings kept):
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 MFHI, 0101 SLT (signed).
  - 0110 SUB, 0111 SLTU (unsigned, as today), 1000 SLL, 1001 SRL, 1010 SRA, 1011 MFLO.
  - 1100 MULTU, 1101 MULT, 1110 DIVU, 1111 DIV.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state == IDLE). A request is accepted when in_valid && in_ready.
- Single-cycle ops: IDLE → DONE on accept. alu_result/is_zero are registered that edge; out_valid rises the next cycle (latency 1).
- Mul/div: IDLE → BUSY on accept, for exactly WIDTH iterations → DONE. Total latency WIDTH+1 cycles.
  - MULTU/MULT: {HI,LO} = 2·WIDTH-bit product; alu_result = LO.
  - DIVU/DIV: LO = quotient, HI = remainder; alu_result = LO.
  - HI/LO are updated on the edge entering DONE.
- Signed mul/div: operate on magnitudes, then fix signs afterwards. Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: LO = all ones, HI = in1. Same latency; no error.
- Signed DIV of most-negative ÷ −1: LO = most-negative, HI = 0.
- DONE → IDLE when out_ready. out_valid stays high and alu_result stays stable until then.
- No new request is accepted in the cycle DONE is exited; the next accept is the following cycle.
- Shifts: use in2[SHAMT_W-1:0] only; upper bits ignored. SRA replicates in1[WIDTH-1].
- SLT/SLTU produce result 0 or 1, zero-extended.
- ADD/SUB wrap modulo 2^WIDTH.
- MFHI/MFLO return HI/LO as of the last completed mul/div; 0 after reset.
- Unknown opcodes: none exist; all 16 codes are defined.
- Reset (any state, including mid-BUSY): state = IDLE, in-flight operation discarded, HI = LO = 0, alu_result = 0, is_zero = 1, out_valid = 0, overflow = 0. in_ready is high once reset deasserts.
- in_valid while not ready: ignored. Operands are not captured and there is no side effect.

Optional Feature:
- Macro: MIPS_ALU_OVERFLOW_EN.
- Defined: overflow is registered with the result. It is 1 for ADD when in1, in2 share a sign and the result sign differs, and for SUB when in1, in2 differ in sign and the result sign differs from in1. It is 0 for all other ops.
- When overflow = 1, the wrapped result is still returned; trap handling is the control unit's job.
- Not defined: overflow is tied to 0 and no detection logic is built.

Decomposition:
- Package mips_alu_pkg:
  - 4-bit opcode localparams (OP_AND … OP_DIV).
  - FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE).
  - helper function is_muldiv(op).
- Sub-module mips_alu_muldiv (WIDTH):
  - iterative shift-add multiplier / restoring divider with start, busy, done, hi, lo.
  - top instantiates it and owns the FSM, HI/LO, the single-cycle datapath and the handshake.

Test Plan:
- Reset mid-MULT (assert rst at iteration 5) → next cycle in_ready=1, out_valid=0, MFHI then MFLO both return 0, is_zero=1.
- ADD 0x7FFFFFFF+1 → out_valid 1 cycle after accept, result 0x80000000, is_zero=0; overflow=1 only with MIPS_ALU_OVERFLOW_EN. SUB 5−5 → 0, is_zero=1.
- SLT 0xFFFFFFFF,1 → 1; SLTU same operands → 0; SRA 0x80000000 by in2=0x24 (shamt 4) → 0xF8000000.
- MULT −3×7 → out_valid exactly 33 cycles after accept, LO=0xFFFFFFEB; MFHI → 0xFFFFFFFF. MULTU 0xFFFFFFFF² → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7÷2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 9÷0 → LO=0xFFFFFFFF, HI=9.
- Hold out_ready=0 for 10 cycles after an AND result → out_valid and result stable, in_ready=0, in_valid pulses ignored. Raise out_ready → IDLE next cycle; next request accepted the cycle after.
